// File: rtl/cam_ctrl_pkg.sv
// cam_ctrl_pkg: op encodings and FSM state type for the CAM request controller.
package cam_ctrl_pkg;
  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_DELETE = 2'b10;
  localparam int STATE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    S_IDLE, S_SEARCH, S_EVAL, S_WRITE, S_WAIT_BUSY, S_RESP
  } state_t;
endpackage

// File: rtl/cam_free_enc.sv
// cam_free_enc: lowest-index free entry finder over the valid vector.
module cam_free_enc #(
  parameter int AW = 2
) (
  input  logic [(1<<AW)-1:0] valid,
  output logic               any_free,
  output logic [AW-1:0]      free_idx
);
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = (1 << AW) - 1; i >= 0; i--)
      if (!valid[i]) begin
        any_free = 1'b1;
        free_idx = AW'(i);
      end
  end
endmodule

// File: rtl/cam_ctrl.sv
// cam_ctrl: serialises lookup/insert/delete requests onto a CAM and owns its valid bits.
// Define CAM_CTRL_DELETE_EN to enable the delete op; otherwise op 10 is rejected as reserved.
module cam_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 2,
  parameter int SEARCH_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  rsp_valid,
  output logic                  rsp_hit,
  output logic [ADDR_WIDTH-1:0] rsp_addr,
  output logic                  rsp_err,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  cam_write_enable,
  output logic [DATA_WIDTH-1:0] cam_din,
  output logic [DATA_WIDTH-1:0] cam_cmp_din,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  input  logic                  cam_busy,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr
);
  localparam int N  = 1 << ADDR_WIDTH;
  localparam int CW = ADDR_WIDTH + 1;
  localparam int LW = $clog2(SEARCH_LAT + 1);
`ifdef CAM_CTRL_DELETE_EN
  localparam bit DEL = 1'b1;
`else
  localparam bit DEL = 1'b0;
`endif
  state_t state, state_n;
  logic [1:0]            op_q;
  logic [DATA_WIDTH-1:0] key_q;
  logic [N-1:0]          valid;
  logic [ADDR_WIDTH-1:0] slot_q, slot_n, free_idx;
  logic [LW-1:0]         lat_cnt;
  logic [CW-1:0]         cnt_n;
  logic hit_q, err_q, any_free, hit, op_ok, accept;
  cam_free_enc #(.AW(ADDR_WIDTH)) u_free (.valid(valid), .any_free(any_free), .free_idx(free_idx));
  assign accept = req_valid && req_ready;
  assign op_ok  = req_op == OP_LOOKUP || req_op == OP_INSERT || (DEL && req_op == OP_DELETE);
  assign hit    = cam_match && valid[cam_match_addr];
  // Reusing a stale copy of the key keeps the CAM free of duplicate entries.
  assign slot_n = (cam_match && !valid[cam_match_addr]) ? cam_match_addr : free_idx;
  always_comb begin
    cnt_n = '0;
    for (int i = 0; i < N; i++) cnt_n += CW'(valid[i]);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      op_q    <= '0;
      key_q   <= '0;
      valid   <= '0;
      slot_q  <= '0;
      hit_q   <= 1'b0;
      err_q   <= 1'b0;
      lat_cnt <= '0;
      count   <= '0;
      full    <= 1'b0;
    end else begin
      state   <= state_n;
      count   <= cnt_n;
      full    <= &valid;
      lat_cnt <= state == S_SEARCH ? lat_cnt + 1'b1 : '0;
      if (state == S_IDLE && accept) begin
        op_q   <= req_op;
        key_q  <= req_key;
        hit_q  <= 1'b0;
        slot_q <= '0;
        err_q  <= !op_ok;
      end
      if (state == S_EVAL) begin
        hit_q  <= hit;
        slot_q <= hit ? cam_match_addr : (op_q == OP_INSERT && any_free) ? slot_n : '0;
        err_q  <= op_q == OP_INSERT && !hit && !any_free;
        if (DEL && op_q == OP_DELETE && hit) valid[cam_match_addr] <= 1'b0;
      end
      if (state == S_WRITE) valid[slot_q] <= 1'b1;
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:      if (accept) state_n = op_ok ? S_SEARCH : S_RESP;
      S_SEARCH:    if (lat_cnt == LW'(SEARCH_LAT - 1)) state_n = S_EVAL;
      S_EVAL:      state_n = (op_q == OP_INSERT && !hit && any_free) ? S_WRITE : S_RESP;
      S_WRITE:     state_n = S_WAIT_BUSY;
      S_WAIT_BUSY: if (!cam_busy) state_n = S_RESP;
      default:     state_n = S_IDLE;
    endcase
  end
  always_comb begin
    req_ready        = rst && state == S_IDLE && !cam_busy;
    rsp_valid        = state == S_RESP;
    rsp_hit          = rsp_valid && hit_q;
    rsp_err          = rsp_valid && err_q;
    rsp_addr         = rsp_valid ? slot_q : '0;
    cam_din          = state != S_IDLE ? key_q : '0;
    cam_write_enable = state == S_WRITE;
    cam_cmp_din      = cam_write_enable ? key_q : '0;
    cam_write_addr   = cam_write_enable ? slot_q : '0;
  end
endmodule

// File: tb/tb_cam_ctrl.sv
// tb_cam_ctrl: directed bench for cam_ctrl with a registered-match CAM model attached.
module tb_cam_ctrl;
  logic clk = 1'b0, rst = 1'b0;
  logic req_valid = 1'b0, req_ready;
  logic [1:0] req_op = 2'b00;
  logic [3:0] req_key = 4'h0;
  logic rsp_valid, rsp_hit, rsp_err, full;
  logic [1:0] rsp_addr;
  logic [2:0] count;
  logic cam_write_enable, cam_busy, cam_match;
  logic [3:0] cam_din, cam_cmp_din;
  logic [1:0] cam_write_addr, cam_match_addr;
  logic [3:0] mem [4];
  logic m_busy = 1'b0, force_busy = 1'b0, m_found;
  logic [1:0] m_idx;
  int errors = 0, checks = 0;
  logic hit, err, we, seen;
  logic [1:0] addr;
  int lat;

  always #5 clk = ~clk;

  cam_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_key(req_key), .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr),
    .rsp_err(rsp_err), .full(full), .count(count), .cam_write_enable(cam_write_enable),
    .cam_din(cam_din), .cam_cmp_din(cam_cmp_din), .cam_write_addr(cam_write_addr),
    .cam_busy(cam_busy), .cam_match(cam_match), .cam_match_addr(cam_match_addr)
  );

  // CAM model: contents start at zero, lowest matching address wins, busy for one cycle after a write
  initial for (int i = 0; i < 4; i++) mem[i] = 4'h0;
  always_comb begin
    m_found = 1'b0;
    m_idx = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (mem[i] == cam_din) begin
        m_found = 1'b1;
        m_idx = 2'(i);
      end
  end
  initial begin
    cam_match = 1'b0;
    cam_match_addr = 2'd0;
  end
  always @(posedge clk) begin
    cam_match <= m_found;
    cam_match_addr <= m_idx;
    m_busy <= cam_write_enable;
    if (cam_write_enable) mem[cam_write_addr] <= cam_cmp_din;
  end
  assign cam_busy = m_busy | force_busy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [1:0] op, input logic [3:0] key, output logic h,
                        output logic [1:0] a, output logic e, output int l, output logic w);
    h = 1'b0; a = 2'd0; e = 1'b0; l = 0; w = 1'b0;
    req_op = op; req_key = key; req_valid = 1'b1;
    for (int i = 0; i < 50 && !req_ready; i++) @(negedge clk);
    chk("accept", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 1; k <= 20 && l == 0; k++) begin
      @(negedge clk);
      if (cam_write_enable) w = 1'b1;
      if (rsp_valid) begin
        l = k; h = rsp_hit; a = rsp_addr; e = rsp_err;
      end
    end
    chk("rsp_seen", 32'(l != 0), 32'd1);
    @(negedge clk);
    chk("rsp_pulse", 32'(rsp_valid), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_hit, rsp_err, rsp_addr}), 32'd0);
    chk("rst_cam", 32'({cam_write_enable, cam_din, cam_cmp_din, cam_write_addr}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(req_ready), 32'd1);
    // stale zero contents must be masked
    do_req(2'b00, 4'h0, hit, addr, err, lat, we);
    chk("lk0_hit", 32'(hit), 32'd0);
    chk("lk0_lat", 32'(lat), 32'd3);
    chk("lk0_count", 32'(count), 32'd0);
    do_req(2'b01, 4'h3, hit, addr, err, lat, we);
    chk("ins3", 32'({hit, err, we, addr}), 32'b0_0_1_00);
    chk("ins3_lat", 32'(lat), 32'd6);
    do_req(2'b01, 4'h5, hit, addr, err, lat, we);
    chk("ins5", 32'({hit, err, we, addr}), 32'b0_0_1_01);
    do_req(2'b01, 4'hB, hit, addr, err, lat, we);
    chk("insB", 32'({hit, err, we, addr}), 32'b0_0_1_10);
    chk("cnt3", 32'({full, count}), 32'b0_011);
    do_req(2'b01, 4'hF, hit, addr, err, lat, we);
    chk("insF", 32'({hit, err, we, addr}), 32'b0_0_1_11);
    chk("cnt4", 32'({full, count}), 32'b1_100);
    do_req(2'b01, 4'h5, hit, addr, err, lat, we);
    chk("dup5", 32'({hit, err, we, addr}), 32'b1_0_0_01);
    chk("dup5_lat", 32'(lat), 32'd3);
    do_req(2'b01, 4'h7, hit, addr, err, lat, we);
    chk("ins7_full", 32'({hit, err, we, addr}), 32'b0_1_0_00);
    do_req(2'b00, 4'h7, hit, addr, err, lat, we);
    chk("lk7", 32'({hit, err, addr}), 32'b0_0_00);
    do_req(2'b00, 4'hB, hit, addr, err, lat, we);
    chk("lkB", 32'({hit, err, addr}), 32'b1_0_10);
    chk("lkB_lat", 32'(lat), 32'd3);
    do_req(2'b11, 4'h3, hit, addr, err, lat, we);
    chk("resv", 32'({hit, err, we, addr}), 32'b0_1_0_00);
    chk("resv_lat", 32'(lat), 32'd1);
`ifdef CAM_CTRL_DELETE_EN
    do_req(2'b10, 4'h5, hit, addr, err, lat, we);
    chk("del5", 32'({hit, err, we, addr}), 32'b1_0_0_01);
    chk("del5_cnt", 32'({full, count}), 32'b0_011);
    do_req(2'b01, 4'h5, hit, addr, err, lat, we);
    chk("reins5", 32'({hit, err, we, addr}), 32'b0_0_1_01);
    chk("reins5_cnt", 32'({full, count}), 32'b1_100);
`else
    do_req(2'b10, 4'h5, hit, addr, err, lat, we);
    chk("del_off", 32'({hit, err, we, addr}), 32'b0_1_0_00);
    chk("del_off_lat", 32'(lat), 32'd1);
    chk("del_off_cnt", 32'({full, count}), 32'b1_100);
`endif
    force_busy = 1'b1;
    repeat (3) @(negedge clk);
    chk("busy_ready", 32'(req_ready), 32'd0);
    force_busy = 1'b0;
    #1 chk("busy_drop", 32'(req_ready), 32'd1);
    @(negedge clk);
    // reset in the middle of an insert abandons it silently
    req_op = 2'b01; req_key = 4'h9; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    chk("mid_rst_rsp", 32'(seen), 32'd0);
    chk("mid_rst_cnt", 32'({full, count}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    do_req(2'b00, 4'h3, hit, addr, err, lat, we);
    chk("post_rst_lk3", 32'({hit, err, addr}), 32'b0_0_00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
